// File: rtl/fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// fft_bitrev_reorder: puts R22Sdf bit-reversed output frames back into natural order.
// A ping-pong pair of LEN-deep banks is used; the bank select is the RAM address MSB.
module fft_bitrev_reorder #(
   parameter int STG = 2,
   parameter int DW  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [2*DW-1:0] in,
   input  logic            in_sync,
   output logic [2*DW-1:0] out,
   output logic            out_valid,
   output logic            out_sync,
   output logic            frame_err
);
   localparam int AW  = 2*STG;
   localparam int LEN = 1 << AW;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [AW-1:0]   wcnt_q, wcnt_d;
   logic            wsel_q, wsel_d;
   logic            frame_err_q, frame_err_d;
   logic [2*DW-1:0] out_q;
   logic            out_valid_q, out_valid_d;
   logic            out_sync_q, out_sync_d;
   logic            wr_en, rd_en, resync;
   logic [AW:0]     waddr, raddr;
   logic [2*DW-1:0] mem [0:2*LEN-1];

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      return r;
   endfunction

   // In IDLE wcnt is always 0, so resync can only fire once a frame is in progress.
   assign resync = en && in_sync && (wcnt_q != '0);
   assign waddr  = {wsel_q, resync ? {AW{1'b0}} : bitrev(wcnt_q)};
   assign raddr  = {~wsel_q, wcnt_q};

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      wsel_d      = wsel_q;
      frame_err_d = frame_err_q;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      if (en) begin
         if (state_q == S_IDLE) begin
            if (in_sync) begin
               wr_en   = 1'b1;
               wcnt_d  = {{(AW-1){1'b0}}, 1'b1};
               state_d = S_FILL;
            end
         end else if (resync) begin
            wr_en       = 1'b1;
            wcnt_d      = {{(AW-1){1'b0}}, 1'b1};
            state_d     = S_FILL;
            frame_err_d = 1'b1;
         end else begin
            wr_en  = 1'b1;
            rd_en  = (state_q == S_STREAM);
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == {AW{1'b1}}) begin
               wsel_d  = ~wsel_q;
               state_d = S_STREAM;
            end
         end
      end
      out_valid_d = rd_en;
      out_sync_d  = rd_en && (wcnt_q == '0);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[waddr] <= in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         wsel_q      <= 1'b0;
         frame_err_q <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_sync_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         wsel_q      <= wsel_d;
         frame_err_q <= frame_err_d;
         out_valid_q <= out_valid_d;
         out_sync_q  <= out_sync_d;
         if (rd_en) out_q <= mem[raddr];
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_sync  = out_sync_q;
   assign frame_err = frame_err_q;
endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fft_bitrev_reorder: frame table plus hand-written resync/reset sequences,
// checked against a queue of natural-order samples.
module tb_fft_bitrev_reorder;
   logic        clk = 1'b0;
   logic        rst, en, in_sync;
   logic [31:0] din, dout;
   logic        out_valid, out_sync, frame_err;

   fft_bitrev_reorder #(.STG(2), .DW(16)) dut (
      .clk(clk), .rst(rst), .en(en), .in(din), .in_sync(in_sync),
      .out(dout), .out_valid(out_valid), .out_sync(out_sync), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct { int base; int stall_at; int stall_len; bit arm; } frame_t;
   typedef struct { logic [31:0] d; logic s; } exp_t;

   frame_t      tbl [4];
   exp_t        q [$];
   int          tests = 0, fails = 0;
   int          cyc = 0, t0 = 0, sync_cyc = -1;
   int          first_v = -1, last_v = 0, nval = 0;
   logic [31:0] last_out = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int br4(input int k);
      logic [3:0] a;
      a = k[3:0];
      return int'({a[0], a[1], a[2], a[3]});
   endfunction

   function automatic logic [31:0] mk(input int v);
      logic [15:0] r;
      r = v[15:0];
      return {r, ~r + 16'd1};
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         nval++;
         if (first_v < 0) first_v = cyc;
         last_v   = cyc;
         last_out = dout;
         if (out_sync && sync_cyc < 0) sync_cyc = cyc;
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got data %0h expected no output", dout);
         end else begin
            e = q.pop_front();
            check("out_data", dout, e.d);
            check("out_sync", {31'b0, out_sync}, {31'b0, e.s});
         end
      end else begin
         check("sync_without_valid", {31'b0, out_sync}, 32'h0);
      end
   end

   task automatic drive(input logic e, input logic s, input logic [31:0] d, input bit mark);
      @(negedge clk);
      #1;
      if (mark) begin
         t0       = cyc;
         sync_cyc = -1;
      end
      en      = e;
      in_sync = s;
      din     = d;
   endtask

   task automatic send_frame(input int base, input int stall_at, input int stall_len,
                             input int k_lo, input int k_hi, input bit arm, input bit push);
      for (int k = k_lo; k <= k_hi; k++) begin
         if (k == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               drive(1'b0, 1'b0, 32'h0, 1'b0);
               if (s > 0) begin
                  check("stall_hold", dout, last_out);
                  check("stall_valid_low", {31'b0, out_valid}, 32'h0);
               end
            end
         end
         drive(1'b1, (k == 0), mk(base + br4(k)), arm && (k == 0));
      end
      if (push) begin
         for (int n = 0; n < 16; n++) q.push_back('{d: mk(base + n), s: (n == 0)});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{base: 0,   stall_at: -1, stall_len: 0, arm: 1'b1};
      tbl[1] = '{base: 100, stall_at: -1, stall_len: 0, arm: 1'b0};
      tbl[2] = '{base: 200, stall_at: 5,  stall_len: 3, arm: 1'b0};
      tbl[3] = '{base: 300, stall_at: -1, stall_len: 0, arm: 1'b0};

      rst = 1'b0; en = 1'b0; in_sync = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      check("reset_out", dout, 32'h0);
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      check("reset_sync", {31'b0, out_sync}, 32'h0);
      check("reset_err", {31'b0, frame_err}, 32'h0);
      rst = 1'b1;

      // Leading junk with no in_sync must be dropped.
      for (int j = 0; j < 5; j++) drive(1'b1, 1'b0, mk(900 + j), 1'b0);

      first_v = -1;
      nval    = 0;
      for (int i = 0; i < 4; i++) begin
         send_frame(tbl[i].base, tbl[i].stall_at, tbl[i].stall_len, 0, 15, tbl[i].arm, 1'b1);
         if (i == 1) check("first_sync_latency", sync_cyc - t0, 17);
      end

      // Partial frame, then in_sync at wcnt=7.
      send_frame(400, -1, 0, 0, 6, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("stream_gaps", (last_v - first_v + 1) - nval, 3);
      check("stream_count", nval, 55);
      check("pending_before_resync", q.size(), 9);
      check("no_err_before_resync", {31'b0, frame_err}, 32'h0);
      q.delete();
      t0       = cyc;
      sync_cyc = -1;
      en = 1'b1; in_sync = 1'b1; din = mk(500);
      send_frame(500, -1, 0, 1, 15, 1'b0, 1'b1);
      check("err_after_resync", {31'b0, frame_err}, 32'h1);
      send_frame(600, -1, 0, 0, 15, 1'b0, 1'b1);
      check("resync_sync_latency", sync_cyc - t0, 17);
      check("err_sticky", {31'b0, frame_err}, 32'h1);

      // Async reset pulse between edges, right after a valid output.
      send_frame(700, -1, 0, 0, 4, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_out", dout, 32'h0);
      check("async_rst_valid", {31'b0, out_valid}, 32'h0);
      check("async_rst_sync", {31'b0, out_sync}, 32'h0);
      check("async_rst_err", {31'b0, frame_err}, 32'h0);
      q.delete();
      #1 rst = 1'b1;

      for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, mk(950 + j), 1'b0);
      send_frame(0, -1, 0, 0, 15, 1'b1, 1'b1);
      send_frame(800, -1, 0, 0, 15, 1'b0, 1'b1);
      check("recovery_sync_latency", sync_cyc - t0, 17);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      check("last_frame_held", q.size(), 16);
      @(negedge clk);
      check("idle_valid_low", {31'b0, out_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the R22Sdf pipeline.
- Converts its bit-reversed-order output frames (LEN = 4**STG complex samples) back to natural order, using a ping-pong pair of LEN-deep buffers.
- Frame boundaries come from the FFT's sync pulse.
- Output is continuous natural-order frames, marked by out_sync, for the downstream magnitude/detector logic.

Parameters:
- STG, 2, number of radix-2^2 stages; LEN = 4**STG, address width AW = 2*STG.
- DW, 16, width of each of re/im (matches cplx_t of R22SdfDefinesPkg).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  sample strobe; a beat is accepted on a clk edge with en=1.
- in  in  2*DW  cplx_t sample from R22Sdf, bit-reversed order.
- in_sync  in  1  qualifies the beat carrying bit-reversed index 0 of a frame.
- out  out  2*DW  cplx_t sample, natural order.
- out_valid  out  1  out holds a valid sample this cycle.
- out_sync  out  1  out holds natural index 0 of a frame; a subset of out_valid.
- frame_err  out  1  sticky; in_sync seen with write counter not 0.

Behaviour:
- Reset (rst=0, async):
  - out=0, out_valid=0, out_sync=0, frame_err=0.
  - wcnt=0, rcnt=0, bank select wsel=0, state=IDLE.
  - Buffer contents are not reset.
- States and transitions:
  - IDLE: beats are discarded until a beat with in_sync=1; that beat is written as index 0, then state goes to FILL.
  - FILL: first frame is being written; no output.
  - STREAM: writing frame f+1 while reading frame f.
- Write side, per accepted beat (not IDLE):
  - Write in to bank wsel at address bitrev_AW(wcnt); bit 0 swaps with bit AW-1, and so on.
  - wcnt increments mod LEN.
  - On the beat where wcnt==LEN-1: wsel toggles; FILL goes to STREAM, and STREAM stays STREAM.
- Read side, per accepted beat in STREAM:
  - Read bank ~wsel at address rcnt; rcnt increments mod LEN.
  - The read-side rcnt equals wcnt by construction.
- Output register:
  - out and out_valid are registered one cycle after the read beat.
  - out_valid=1 in the cycle after every accepted STREAM beat, else 0.
  - out_sync=1 when that beat had rcnt==0.
- Latency, in en-beats:
  - Natural index n of frame f appears on out one clk after beat LEN+n, counted from the frame's index-0 beat (beat 0).
  - With en held high, the first out_sync comes LEN+1 clocks after the first in_sync beat.
- en=0 stalls:
  - No write, no read, no counter change.
  - out keeps its value; out_valid=0 and out_sync=0 the next cycle.
  - Output advances only with input; the last frame stays in the buffer until the next frame's beats arrive (no flush).
- in_sync on the index-0 beat (wcnt==0): accepted silently; no error.
- in_sync with wcnt!=0 (resync):
  - The partial frame is discarded; this beat is written as index 0 and wcnt becomes 1.
  - State goes to FILL; out_valid is suppressed until the next full frame completes.
  - frame_err is set and stays set until reset.
- in_sync absent: frames self-time from wcnt wrap.
- Reset mid-operation: all state clears immediately and the next frame must begin with in_sync.
- Width rules:
  - Data passes through unmodified; no arithmetic.
  - Buffers are 2 x LEN x 2*DW, inferred as dual-port RAM (one write port, one sync-read port); bank select is the address MSB.

Test Plan (STG=2, LEN=16, AW=4):
- Ramp: en=1 continuously; frame beats k=0..15 carry re=bitrev4(k) (0,8,4,12,2,...), im=-re; in_sync on k=0.
  - Required: first out_sync 17 clocks after in_sync, then re=0,1,...,15 with im=-re.
  - out_valid stays high continuously while frames continue.
- Back-to-back frames: frame A re=k+100, frame B re=k+200 (pre-reversed).
  - Required: naturally ordered A is followed immediately by B, with no gap and out_sync every 16 valid cycles.
- Stall: drop en for 3 cycles at beat 5 of frame 2.
  - Required: no lost or duplicated samples; out_valid is low for exactly 3 cycles, with the sequence intact.
- Resync: assert in_sync at wcnt=7.
  - Required: frame_err=1 and stays set; output is suppressed.
  - The next out_sync comes 17 beats after the resync beat, with correct order.
- Async reset: pulse rst low mid-STREAM, between clock edges.
  - Required: outputs are 0 before the next edge; beats without in_sync are ignored (IDLE).
  - Recovery follows the ramp scenario timing.
- Leading junk: 5 beats with in_sync=0 after reset, then a ramp frame.
  - Required: the junk is discarded; the output matches the ramp scenario.
